// File: rtl/count_seq_checker.sv
// Monitor for a free-running CW-bit up counter: locks onto the +1 sequence,
// reports and counts locked wraps, and flags/counts out-of-sequence steps.
module count_seq_checker #(
    parameter int unsigned CW     = 3,
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned ERR_W  = 4,
    parameter int unsigned LOCK_N = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW-1:0]     count_in,
    input  logic              clear,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        ST_ACQ,
        ST_SYNC,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     prev_q, prev_d;
    logic [7:0]        good_q, good_d;
    logic              wrap_q, wrap_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic ok;
    logic at_max;

    // The max->0 step is naturally ok because the sum is truncated to CW bits.
    assign ok     = (count_in == CW'(prev_q + CW'(1)));
    assign at_max = (prev_q == '1);

    always_comb begin
        state_d    = state_q;
        prev_d     = count_in;
        good_d     = good_q;
        wrap_d     = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        err_cnt_d  = err_cnt_q;

        if (clear) begin
            state_d    = ST_ACQ;
            good_d     = '0;
            wrap_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_ACQ: begin
                    state_d = ST_SYNC;
                    good_d  = '0;
                end
                ST_SYNC: begin
                    if (ok) begin
                        good_d = good_q + 8'd1;
                        if (({1'b0, good_q} + 9'd1) == 9'(LOCK_N)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (ok) begin
                        if (at_max) begin
                            wrap_d = 1'b1;
                            if (wrap_cnt_q != '1) begin
                                wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                            end
                        end
                    end else begin
                        state_d = ST_FAULT;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_ACQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ACQ;
            prev_q     <= '0;
            good_q     <= '0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            good_q     <= good_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign wrap     = wrap_q;
    assign wrap_cnt = wrap_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign locked   = (state_q == ST_LOCKED);
    assign err      = (state_q == ST_FAULT);

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios plus randomized glitches,
// clears and resets, all compared against a run-length reference model.
module tb_count_seq_checker;

    localparam int unsigned LOCK_N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [2:0] count_in = '0;

    logic       wrap, locked, err;
    logic [7:0] wrap_cnt;
    logic [3:0] err_cnt;
    logic       s_wrap, s_locked, s_err;
    logic [1:0] s_wrap_cnt;
    logic [3:0] s_err_cnt;

    count_seq_checker #(.CW(3), .WRAP_W(8), .ERR_W(4), .LOCK_N(LOCK_N)) u_dut (
        .clk(clk), .reset(reset), .count_in(count_in), .clear(clear),
        .wrap(wrap), .wrap_cnt(wrap_cnt), .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    count_seq_checker #(.CW(3), .WRAP_W(2), .ERR_W(4), .LOCK_N(LOCK_N)) u_sat (
        .clk(clk), .reset(reset), .count_in(count_in), .clear(clear),
        .wrap(s_wrap), .wrap_cnt(s_wrap_cnt), .locked(s_locked), .err(s_err), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: acquisition flag, length of the current run of good
    // steps, a fault flag and raw event counts.
    int m_prev = 0;
    bit m_acq  = 0;
    int m_run  = 0;
    bit m_fault = 0;
    bit m_wrap = 0;
    int m_wraps = 0;
    int m_errs  = 0;

    int ctr = 0;
    int sat_pulses = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step(input int cin, input bit clr, input bit rst);
        if (rst || clr) begin
            m_prev  = rst ? 0 : cin;
            m_acq   = 0;
            m_run   = 0;
            m_fault = 0;
            m_wrap  = 0;
            m_wraps = 0;
            m_errs  = 0;
        end else begin
            m_wrap = 0;
            if (!m_acq) begin
                m_acq = 1;
                m_run = 0;
            end else if (!m_fault) begin
                if (m_run >= LOCK_N) begin
                    if (cin == (m_prev + 1) % 8) begin
                        if (cin == 0) begin
                            m_wrap = 1;
                            m_wraps++;
                        end
                    end else begin
                        m_fault = 1;
                        m_errs++;
                    end
                end else begin
                    m_run = (cin == (m_prev + 1) % 8) ? m_run + 1 : 0;
                end
            end
            m_prev = cin;
        end
    endtask

    task automatic cycle(input int cin, input bit clr, input bit rst);
        bit exp_lock;
        count_in = 3'(cin);
        clear    = clr;
        reset    = rst;
        @(posedge clk);
        model_step(cin, clr, rst);
        #1;
        exp_lock = m_acq && !m_fault && (m_run >= LOCK_N);
        check_eq("wrap",       32'(wrap),       32'(m_wrap));
        check_eq("wrap_cnt",   32'(wrap_cnt),   32'(sat(m_wraps, 255)));
        check_eq("locked",     32'(locked),     32'(exp_lock));
        check_eq("err",        32'(err),        32'(m_fault));
        check_eq("err_cnt",    32'(err_cnt),    32'(sat(m_errs, 15)));
        check_eq("s_wrap",     32'(s_wrap),     32'(m_wrap));
        check_eq("s_wrap_cnt", 32'(s_wrap_cnt), 32'(sat(m_wraps, 3)));
        check_eq("s_locked",   32'(s_locked),   32'(exp_lock));
        if (s_wrap) sat_pulses++;
    endtask

    task automatic run_clean(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(ctr, 1'b0, 1'b0);
            ctr = (ctr + 1) % 8;
        end
    endtask

    initial begin
        int glitch_seq[8] = '{0, 1, 2, 6, 7, 0, 1, 2};

        // 1: clean lock and wrap, reset shared with the counter
        cycle(0, 1'b0, 1'b1);
        cycle(0, 1'b0, 1'b1);
        check_eq("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        ctr = 0;
        run_clean(4);
        check_eq("t1_not_yet_locked", 32'(locked), 32'd0);
        run_clean(1);
        check_eq("t1_locked", 32'(locked), 32'd1);
        run_clean(4);
        check_eq("t1_wrap", 32'(wrap), 32'd1);
        check_eq("t1_wrap_cnt", 32'(wrap_cnt), 32'd1);
        run_clean(16);
        check_eq("t1_wrap_cnt3", 32'(wrap_cnt), 32'd3);
        check_eq("t1_err", 32'(err), 32'd0);

        // 2: fault on a 3 -> 5 step
        run_clean(3);
        cycle(5, 1'b0, 1'b0);
        ctr = 6;
        check_eq("t2_err", 32'(err), 32'd1);
        check_eq("t2_locked", 32'(locked), 32'd0);
        check_eq("t2_err_cnt", 32'(err_cnt), 32'd1);
        run_clean(8);
        check_eq("t2_wrap_cnt_hold", 32'(wrap_cnt), 32'd3);
        check_eq("t2_err_sticky", 32'(err), 32'd1);

        // 3: clear recovery
        cycle(ctr, 1'b1, 1'b0);
        ctr = (ctr + 1) % 8;
        check_eq("t3_err", 32'(err), 32'd0);
        check_eq("t3_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("t3_wrap_cnt", 32'(wrap_cnt), 32'd0);
        run_clean(4);
        check_eq("t3_not_yet_locked", 32'(locked), 32'd0);
        run_clean(1);
        check_eq("t3_relocked", 32'(locked), 32'd1);

        // 4: glitch during SYNC restarts the good-step run
        cycle(ctr, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(glitch_seq[i], 1'b0, 1'b0);
            if (i == 6) check_eq("t4_not_locked", 32'(locked), 32'd0);
        end
        check_eq("t4_locked", 32'(locked), 32'd1);
        check_eq("t4_err_cnt", 32'(err_cnt), 32'd0);
        ctr = 3;

        // 5: six wraps, narrow counter saturates
        sat_pulses = 0;
        run_clean(48);
        check_eq("t5_sat_cnt", 32'(s_wrap_cnt), 32'd3);
        check_eq("t5_sat_pulses", 32'(sat_pulses), 32'd6);
        check_eq("t5_wide_cnt", 32'(wrap_cnt), 32'd6);

        // 6: reset beats clear; reset out of FAULT
        cycle(ctr, 1'b1, 1'b1);
        ctr = 0;
        check_eq("t6_locked", 32'(locked), 32'd0);
        check_eq("t6_wrap_cnt", 32'(wrap_cnt), 32'd0);
        run_clean(5);
        check_eq("t6_relock", 32'(locked), 32'd1);
        cycle((ctr + 2) % 8, 1'b0, 1'b0);
        check_eq("t6_fault", 32'(err), 32'd1);
        cycle(0, 1'b0, 1'b1);
        ctr = 0;
        check_eq("t6_rst_err", 32'(err), 32'd0);
        check_eq("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
        run_clean(5);
        check_eq("t6_reacq", 32'(locked), 32'd1);

        // randomized glitches, clears and resets
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 1) begin
                cycle(ctr, 1'b0, 1'b1);
                ctr = 0;
            end else if (r < 3) begin
                cycle(ctr, 1'b1, 1'b0);
                ctr = (ctr + 1) % 8;
            end else if (r < 6) begin
                ctr = int'($urandom_range(0, 7));
                cycle(ctr, 1'b0, 1'b0);
                ctr = (ctr + 1) % 8;
            end else begin
                run_clean(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/count_seq_checker.md
# count_seq_checker

Downstream monitor for the free-running 3-bit up counter. It samples the counter's `count` output every clock, acquires and locks onto the +1 modulo-2^CW sequence, and then reports each wrap-around (max to 0) as a one-cycle pulse and counts it. After lock, any out-of-sequence step raises a sticky fault and is counted. Wrap and fault outputs feed the status/debug logic that sits after the counter.

## Interface
- `CW`, default 3: width of the monitored count.
- `WRAP_W`, default 8: width of `wrap_cnt`.
- `ERR_W`, default 4: width of `err_cnt`.
- `LOCK_N`, default 4: number of consecutive correct steps required to lock. Legal range is 1 to 255.

Ports:
- `clk`  in  1: single clock. All logic is rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `count_in`  in  CW: sampled counter value. Connects directly to the counter's `count`.
- `clear`  in  1: synchronous soft clear.
- `wrap`  out  1: one-cycle pulse for each valid locked wrap.
- `wrap_cnt`  out  WRAP_W: number of wraps since reset/clear. Saturates.
- `locked`  out  1: high while in state LOCKED.
- `err`  out  1: sticky fault flag. High in state FAULT.
- `err_cnt`  out  ERR_W: number of faults since reset/clear. Saturates.

## Operation
- **Internal registers:**
  - `prev` (CW bits): last sample.
  - `good_cnt` (8 bits).
  - state: ACQ, SYNC, LOCKED, FAULT.
- **Step check:** `ok` = (`count_in` == (`prev` + 1) mod 2^CW). The wrap 2^CW−1 → 0 counts as ok.
- **`prev` update:** `prev` <= `count_in` on every non-reset, non-clear edge, in all states.
- **ACQ:** capture `count_in` into `prev`, then go to SYNC with `good_cnt`=0. No check is made in this state.
- **SYNC:**
  - ok: `good_cnt`++. When `good_cnt`+1 == LOCK_N, go to LOCKED.
  - not ok: `good_cnt`=0 and stay in SYNC.
  - No errors are counted and no wraps are reported in SYNC.
- **LOCKED:**
  - ok with `prev`==2^CW−1 (so `count_in`==0): `wrap`=1 for one cycle, `wrap_cnt`++ saturating at 2^WRAP_W−1.
  - ok otherwise: `wrap`=0.
  - not ok: go to FAULT, `err`=1, `err_cnt`++ saturating at 2^ERR_W−1, `wrap`=0.
- **FAULT:** hold. `err` stays 1, `locked`=0, `wrap`=0. Only `clear` or `reset` leaves this state. `prev` keeps tracking.
- **`clear` (any state):**
  - state goes to ACQ.
  - `good_cnt`, `wrap_cnt`, `err_cnt`, `err`, `wrap` all go to 0.
  - `prev` <= `count_in`.
- **`reset`:** takes priority over `clear`. State goes to ACQ, and `prev` and every output go to 0.
- Simultaneous `clear` and a step event: `clear` wins. The step is not evaluated.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- **Reset values:** `wrap`=0, `wrap_cnt`=0, `locked`=0, `err`=0, `err_cnt`=0, state ACQ.
- **Latency:** an event in the sample taken at edge k appears on the outputs after edge k (one cycle).
- **Lock time:** `locked` rises after the edge that samples the LOCK_N-th consecutive ok step. That is LOCK_N+1 edges after leaving reset/clear when the input is a clean sequence.
- `wrap` is never high for two consecutive cycles at CW ≥ 1.
- `locked` falls on the same edge that `err` rises.
- **Reset mid-operation:**
  - Takes effect on the next edge regardless of state.
  - The first sample after reset deasserts is an ACQ capture.
  - When sharing `reset` with the counter, that capture value is 0.
- **Saturation:** at max, the counters hold. `wrap` still pulses at saturation.

## Test plan
1. **Clean lock and wrap.** Share `reset` with the counter, hold it for 2 cycles, then release. Check:
   - ACQ captures 0; samples 1..4 lock the checker.
   - `locked`=1 after the 5th edge.
   - Samples 5,6,7,0: `wrap` pulses once after the edge that samples 0; `wrap_cnt`=1.
   - After 16 more cycles: `wrap_cnt`=3, `err`=0.
2. **Fault.** While locked, force the sequence 3 → 5. Check:
   - After that edge: `err`=1, `locked`=0, `err_cnt`=1.
   - Subsequent clean counting and passing 7→0 produce no `wrap`; `err` remains 1.
3. **Clear recovery.** From FAULT, pulse `clear` for 1 cycle. Check:
   - All counts and `err` return to 0.
   - Relock occurs after `clear` plus LOCK_N+1 edges (4+1 with default LOCK_N=4) of clean counting.
4. **SYNC glitch.** During SYNC, feed 0,1,2,6,7,0,1,2. Check:
   - `good_cnt` restarts at the 2→6 step.
   - `locked` rises only after 4 ok steps following that break (after sample 2).
   - `err_cnt` stays 0.
5. **Saturation.** Use WRAP_W=2 and run 6 clean wraps. Check:
   - `wrap_cnt` holds at 3.
   - `wrap` still pulses 6 times.
6. **Priority and mid-run reset.**
   - Assert `reset` and `clear` together while LOCKED: reset values result, state ACQ.
   - Assert `reset` for one cycle while in FAULT: all outputs 0 on the next cycle, then normal re-acquisition.
